// File: rtl/sram_burst_ctrl.sv
// Burst controller for a synchronous single-port SRAM: valid/ready command port,
// streamed write data, pipelined read return with per-beat address.
module sram_burst_ctrl #(
    parameter int   DATA_W  = 8,
    parameter int   ADDR_W  = 10,
    parameter int   RD_LAT  = 1,
    parameter logic ACT_LVL = 1'b0
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_rd,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [ADDR_W-1:0] cmd_len,
    input  logic              cmd_dec,
    input  logic              cmd_wrap,
    input  logic [ADDR_W-1:0] cmd_stride,
    input  logic              cmd_abort,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [DATA_W-1:0] wr_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic [ADDR_W-1:0] rd_addr,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic              s_clk,
    output logic              s_cen,
    output logic              s_wen,
    output logic              s_oen,
    output logic [ADDR_W-1:0] s_addr,
    output logic [DATA_W-1:0] s_ddata,
    input  logic [DATA_W-1:0] s_qdata
);

    // state | meaning
    // IDLE  | waiting for a command, cmd_ready high
    // CHECK | one cycle to test the latched burst for address overflow
    // WRITE | one SRAM write per wr_valid/wr_ready handshake
    // READ  | one SRAM read issued every cycle
    // DRAIN | no new reads, waiting for the return pipeline to empty
    typedef enum logic [2:0] {IDLE, CHECK, WRITE, READ, DRAIN} state_t;

    state_t r_state, w_state_nxt;

    logic                r_rd, r_dec, r_wrap;
    logic [ADDR_W-1:0]   r_addr, r_cnt;
    logic [ADDR_W:0]     r_step;
    logic [RD_LAT-1:0]   r_pipe_v;
    logic [ADDR_W-1:0]   r_pipe_a [RD_LAT];

    logic [2*ADDR_W:0]   w_span;
    logic [2*ADDR_W+1:0] w_end;
    logic                w_overflow;
    logic [ADDR_W-1:0]   w_addr_nxt;
    logic                w_issue_wr, w_issue_rd, w_done_nxt, w_err_nxt, w_pipe_busy;

    // span is computed at full width so a long strided burst cannot alias past the top
    assign w_span      = {{(ADDR_W+1){1'b0}}, r_cnt} * {{ADDR_W{1'b0}}, r_step};
    assign w_end       = {1'b0, w_span} + {{(ADDR_W+2){1'b0}}, r_addr};
    assign w_overflow  = !r_wrap && (r_dec ? (w_span > {{(ADDR_W+1){1'b0}}, r_addr})
                                           : (w_end > {{(ADDR_W+2){1'b0}}, {ADDR_W{1'b1}}}));
    assign w_addr_nxt  = r_dec ? r_addr - r_step[ADDR_W-1:0] : r_addr + r_step[ADDR_W-1:0];
    assign w_pipe_busy = |r_pipe_v;

    assign cmd_ready = (r_state == IDLE);
    assign busy      = (r_state != IDLE);
    assign wr_ready  = (r_state == WRITE) && !cmd_abort;
    assign s_clk     = clk;

    always_ff @(posedge clk) begin
        if (!reset_n) r_state <= IDLE;
        else          r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_issue_wr  = 1'b0;
        w_issue_rd  = 1'b0;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            IDLE: begin
                if (cmd_valid) w_state_nxt = CHECK;
            end
            CHECK: begin
                if (w_overflow) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_state_nxt = r_rd ? READ : WRITE;
                end
            end
            WRITE: begin
                w_issue_wr = wr_valid && !cmd_abort;
                if (cmd_abort || (w_issue_wr && r_cnt == '0)) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            READ: begin
                w_issue_rd = !cmd_abort;
                if (cmd_abort || r_cnt == '0) w_state_nxt = DRAIN;
            end
            DRAIN: begin
                if (!w_pipe_busy) begin
                    w_done_nxt  = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_rd     <= 1'b0;
            r_dec    <= 1'b0;
            r_wrap   <= 1'b0;
            r_addr   <= '0;
            r_cnt    <= '0;
            r_step   <= '0;
            r_pipe_v <= '0;
            for (int i = 0; i < RD_LAT; i++) r_pipe_a[i] <= '0;
            s_cen    <= ~ACT_LVL;
            s_wen    <= ~ACT_LVL;
            s_oen    <= ~ACT_LVL;
            s_addr   <= '0;
            s_ddata  <= '0;
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_addr  <= '0;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            if (r_state == IDLE && cmd_valid) begin
                r_rd   <= cmd_rd;
                r_dec  <= cmd_dec;
                r_wrap <= cmd_wrap;
                r_addr <= cmd_addr;
                r_cnt  <= cmd_len;
                r_step <= {1'b0, cmd_stride} + (ADDR_W+1)'(1);
            end
            if (w_issue_wr || w_issue_rd) begin
                r_addr <= w_addr_nxt;
                r_cnt  <= r_cnt - ADDR_W'(1);
                s_addr <= r_addr;
            end
            if (w_issue_wr) s_ddata <= wr_data;
            s_cen <= (w_issue_wr || w_issue_rd) ? ACT_LVL : ~ACT_LVL;
            s_wen <= w_issue_wr ? ACT_LVL : ~ACT_LVL;
            s_oen <= w_issue_rd ? ACT_LVL : ~ACT_LVL;

            // stage 0 lines up with the registered read strobe
            r_pipe_v[0] <= w_issue_rd;
            r_pipe_a[0] <= r_addr;
            for (int i = 1; i < RD_LAT; i++) begin
                r_pipe_v[i] <= r_pipe_v[i-1];
                r_pipe_a[i] <= r_pipe_a[i-1];
            end
            rd_valid <= r_pipe_v[RD_LAT-1];
            if (r_pipe_v[RD_LAT-1]) begin
                rd_data <= s_qdata;
                rd_addr <= r_pipe_a[RD_LAT-1];
            end
            done <= w_done_nxt;
            err  <= w_err_nxt;
        end
    end

endmodule
